ex_mem_stage: RTL and testbench
===============================

EX_MEM_STAGE -- requirements
Module: ex_mem_stage

Interface
REQ-001 SHALL have parameter DATA_W, default 32, datapath width of ALU result, store data and branch target.
REQ-002 SHALL have parameter REG_W, default 5, width of destination register index.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have ports in_valid input 1 (EX entry present) and in_ready output 1 (stage can accept).
REQ-006 SHALL have port alu_result  input  DATA_W  result from ALU.
REQ-007 SHALL have port zero  input  1  ALU zero flag.
REQ-008 SHALL have ports write_data input DATA_W (store data) and write_reg input REG_W (destination index).
REQ-009 SHALL have 1-bit input ports reg_write, mem_read, mem_write, mem_to_reg and branch, which are control bits from decode.
REQ-010 SHALL have port branch_target  input  DATA_W  computed branch address.
REQ-011 SHALL have port flush  input  1  discard all held entries.
REQ-012 SHALL have ports out_valid output 1 (MEM entry present) and out_ready input 1 (MEM consumes).
REQ-013 SHALL have out_alu_result, out_write_data, out_write_reg and out_reg_write/out_mem_read/out_mem_write/out_mem_to_reg outputs, each with the width of its matching input.
REQ-014 SHALL have ports pc_src output 1 and pc_branch output DATA_W, carrying the branch redirect to fetch.

Function
REQ-015 SHALL implement a 2-entry buffer: a head register driving out_*, plus a skid register.
REQ-016 SHALL use occupancy states EMPTY, ONE and FULL; out_valid=1 in ONE/FULL, and in_ready=1 in EMPTY/ONE, driven from registered state only.
REQ-017 SHALL treat acceptance as in_valid&in_ready and departure as out_valid&out_ready.
REQ-018 SHALL make these transitions: EMPTY+accept->ONE; ONE+accept without departure->FULL (entry to skid); ONE+departure without accept->EMPTY; ONE+accept+departure->ONE (new entry to head); FULL+departure->ONE (skid moves to head); other cases hold.
REQ-019 SHALL deliver entries in acceptance order with no loss or duplication; an accepted entry appears at out_* the next cycle at the earliest (latency 1).
REQ-020 SHALL hold out_* stable while out_valid=1 and out_ready=0.
REQ-021 SHALL drive all out_* data and control outputs to 0 when out_valid=0.
REQ-022 SHALL, on flush=1, go to EMPTY next cycle and drop any entry presented in the same cycle; flush overrides accept and departure.
REQ-023 SHALL record, per entry, taken = branch & zero at acceptance, stored alongside the entry.
REQ-024 SHALL pulse pc_src for exactly one cycle, and hold pc_branch = that entry's branch_target for the same cycle, in the cycle after a taken entry is accepted; pc_branch SHALL otherwise be 0.
REQ-025 SHALL NOT raise pc_src for an entry accepted in a cycle with flush=1.

Reset
REQ-026 SHALL, with reset=1 at a clock edge, enter EMPTY, clear both entries, and set out_valid=0, pc_src=0, pc_branch=0 and all out_* to 0.
REQ-027 SHALL, when reset is asserted mid-operation, discard held entries without a departure; reset overrides flush and accept.
REQ-028 SHALL drive in_ready=1 in the first cycle after reset deasserts.

Configuration
REQ-029 SHALL, with macro EX_MEM_BRANCH_EN defined, implement REQ-023 to REQ-025.
REQ-030 SHALL, with EX_MEM_BRANCH_EN undefined, tie pc_src and pc_branch to 0, ignore branch/zero/branch_target, store no taken bit, and leave all other behaviour unchanged.

Verification
REQ-031 SHALL cover single pass: accept alu_result=0x0000_0005, write_reg=3, reg_write=1, out_ready=1 -> next cycle out_valid=1, out_alu_result=5, out_write_reg=3; following cycle out_valid=0.
REQ-032 SHALL cover backpressure: out_ready=0, accept 0xA then 0xB -> in_ready=0 after second; raise out_ready -> outputs 0xA then 0xB, in_ready=1 after first departure.
REQ-033 SHALL cover flush: FULL state, flush=1 with in_valid=1 -> next cycle out_valid=0, in_ready=1; dropped entry never appears.
REQ-034 SHALL cover branch: branch=1, zero=1, branch_target=0x0040_0020 -> one-cycle pc_src=1, pc_branch=0x0040_0020; with zero=0 -> pc_src stays 0; with macro undefined -> pc_src always 0.
REQ-035 SHALL cover reset mid-stream: FULL state, reset=1 one cycle -> out_valid=0, all out_*=0, pc_src=0; buffered entries never emerge.

Source files
------------

// File: rtl/ex_mem_stage_if.sv
// EX/MEM stage bus: the EX-side entry handshake, the MEM-side output handshake,
// the flush request and the branch redirect to fetch.
interface ex_mem_stage_if #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5
);
  // Both handshakes use the same rule: a transfer happens on a rising edge
  // where valid and ready are both 1. The producer must not retract valid or
  // change its data until that edge; ready may change freely.
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] alu_result;
  logic              zero;
  logic [DATA_W-1:0] write_data;
  logic [REG_W-1:0]  write_reg;
  logic              reg_write;
  logic              mem_read;
  logic              mem_write;
  logic              mem_to_reg;
  logic              branch;
  logic [DATA_W-1:0] branch_target;
  logic              flush;

  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_alu_result;
  logic [DATA_W-1:0] out_write_data;
  logic [REG_W-1:0]  out_write_reg;
  logic              out_reg_write;
  logic              out_mem_read;
  logic              out_mem_write;
  logic              out_mem_to_reg;

  logic              pc_src;
  logic [DATA_W-1:0] pc_branch;

  modport master (
    output in_valid, alu_result, zero, write_data, write_reg,
           reg_write, mem_read, mem_write, mem_to_reg, branch, branch_target,
           flush, out_ready,
    input  in_ready, out_valid, out_alu_result, out_write_data, out_write_reg,
           out_reg_write, out_mem_read, out_mem_write, out_mem_to_reg,
           pc_src, pc_branch
  );

  modport slave (
    input  in_valid, alu_result, zero, write_data, write_reg,
           reg_write, mem_read, mem_write, mem_to_reg, branch, branch_target,
           flush, out_ready,
    output in_ready, out_valid, out_alu_result, out_write_data, out_write_reg,
           out_reg_write, out_mem_read, out_mem_write, out_mem_to_reg,
           pc_src, pc_branch
  );
endinterface

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register built as a 2-entry skid buffer with flush.
// Define EX_MEM_BRANCH_EN to enable the taken-branch redirect (pc_src/pc_branch).
module ex_mem_stage #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5
) (
  input  logic          clk,
  input  logic          reset,
  ex_mem_stage_if.slave bus,
  output logic [1:0]    dbg_state,
  output logic          dbg_head_taken
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  typedef struct packed {
    logic [DATA_W-1:0] alu_result;
    logic [DATA_W-1:0] write_data;
    logic [REG_W-1:0]  write_reg;
    logic              reg_write;
    logic              mem_read;
    logic              mem_write;
    logic              mem_to_reg;
`ifdef EX_MEM_BRANCH_EN
    logic              taken;
`endif
  } entry_t;

  state_t state_q, state_d;
  entry_t head_q, head_d;
  entry_t skid_q, skid_d;
  entry_t in_entry;

  logic accept;
  logic depart;

  // Ready/valid come only from registered state, never from out_ready.
  assign bus.in_ready  = (state_q != FULL);
  assign bus.out_valid = (state_q != EMPTY);
  assign accept        = bus.in_valid & bus.in_ready;
  assign depart        = bus.out_valid & bus.out_ready;
  assign dbg_state     = state_q;

  always_comb begin
    in_entry            = '0;
    in_entry.alu_result = bus.alu_result;
    in_entry.write_data = bus.write_data;
    in_entry.write_reg  = bus.write_reg;
    in_entry.reg_write  = bus.reg_write;
    in_entry.mem_read   = bus.mem_read;
    in_entry.mem_write  = bus.mem_write;
    in_entry.mem_to_reg = bus.mem_to_reg;
`ifdef EX_MEM_BRANCH_EN
    in_entry.taken      = bus.branch & bus.zero;
`endif
  end

  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    skid_d  = skid_q;
    if (bus.flush) begin
      state_d = EMPTY;
      head_d  = '0;
      skid_d  = '0;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (accept) begin
            head_d  = in_entry;
            state_d = ONE;
          end
        end
        ONE: begin
          if (accept && !depart) begin
            skid_d  = in_entry;
            state_d = FULL;
          end else if (!accept && depart) begin
            head_d  = '0;
            state_d = EMPTY;
          end else if (accept && depart) begin
            head_d  = in_entry;
          end
        end
        FULL: begin
          if (depart) begin
            head_d  = skid_q;
            skid_d  = '0;
            state_d = ONE;
          end
        end
        default: begin
          state_d = EMPTY;
          head_d  = '0;
          skid_d  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= EMPTY;
      head_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      skid_q  <= skid_d;
    end
  end

  // Head is cleared on leaving, but gate anyway so idle outputs are always zero.
  always_comb begin
    bus.out_alu_result = '0;
    bus.out_write_data = '0;
    bus.out_write_reg  = '0;
    bus.out_reg_write  = 1'b0;
    bus.out_mem_read   = 1'b0;
    bus.out_mem_write  = 1'b0;
    bus.out_mem_to_reg = 1'b0;
    if (bus.out_valid) begin
      bus.out_alu_result = head_q.alu_result;
      bus.out_write_data = head_q.write_data;
      bus.out_write_reg  = head_q.write_reg;
      bus.out_reg_write  = head_q.reg_write;
      bus.out_mem_read   = head_q.mem_read;
      bus.out_mem_write  = head_q.mem_write;
      bus.out_mem_to_reg = head_q.mem_to_reg;
    end
  end

`ifdef EX_MEM_BRANCH_EN
  logic              pc_src_q, pc_src_d;
  logic [DATA_W-1:0] pc_branch_q, pc_branch_d;

  // Redirect fires from the acceptance itself, so it is independent of when
  // the entry later leaves toward MEM; a flushed acceptance never redirects.
  always_comb begin
    pc_src_d    = accept & ~bus.flush & in_entry.taken;
    pc_branch_d = '0;
    if (pc_src_d) pc_branch_d = bus.branch_target;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_src_q    <= 1'b0;
      pc_branch_q <= '0;
    end else begin
      pc_src_q    <= pc_src_d;
      pc_branch_q <= pc_branch_d;
    end
  end

  assign bus.pc_src     = pc_src_q;
  assign bus.pc_branch  = pc_branch_q;
  assign dbg_head_taken = head_q.taken;
`else
  logic unused_branch_inputs;
  assign unused_branch_inputs = ^{bus.branch, bus.zero, bus.branch_target};
  assign bus.pc_src     = 1'b0;
  assign bus.pc_branch  = '0;
  assign dbg_head_taken = 1'b0;
`endif

endmodule

// File: tb/tb_ex_mem_stage.sv
// Bench for ex_mem_stage: directed scenarios plus random traffic, checked by a
// queue-based scoreboard and a negedge monitor.
module tb_ex_mem_stage;
  localparam int DATA_W = 32;
  localparam int REG_W  = 5;
  localparam int EW     = 2 * DATA_W + REG_W + 4;

  logic       clk;
  logic       rst;
  logic [1:0] dbg_state;
  logic       dbg_head_taken;

  ex_mem_stage_if #(.DATA_W(DATA_W), .REG_W(REG_W)) bus ();

  ex_mem_stage #(.DATA_W(DATA_W), .REG_W(REG_W)) dut (
    .clk            (clk),
    .reset          (rst),
    .bus            (bus),
    .dbg_state      (dbg_state),
    .dbg_head_taken (dbg_head_taken)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  logic [EW-1:0]     exp_q[$];
  logic              exp_pc_src;
  logic [DATA_W-1:0] exp_pc_branch;
  logic              mon_en;
  logic              prev_hold;
  logic [EW-1:0]     prev_out;
  int                checks;
  int                failures;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [EW-1:0] pack_out();
    return {bus.out_alu_result, bus.out_write_data, bus.out_write_reg,
            bus.out_reg_write, bus.out_mem_read, bus.out_mem_write, bus.out_mem_to_reg};
  endfunction

  // ---------------- monitor ----------------
  // Inputs are stable at negedge, so a departure seen here happens at the next posedge.
  always @(negedge clk) begin
    if (mon_en) begin
      logic [EW-1:0] got;
      logic [EW-1:0] exp;
      got = pack_out();
      check("out_valid", bus.out_valid, exp_q.size() > 0);
      check("in_ready", bus.in_ready, exp_q.size() < 2);
      check("pc_src", bus.pc_src, exp_pc_src);
      check("pc_branch", bus.pc_branch, exp_pc_branch);
      if (!bus.out_valid) check("idle_outputs_zero", got, '0);
      if (prev_hold) check("stall_stable", got, prev_out);
      if (bus.out_valid && bus.out_ready && !bus.flush && !rst) begin
        if (exp_q.size() == 0) begin
          check("unexpected_departure", 1, 0);
        end else begin
          exp = exp_q.pop_front();
          check("departure_data", got, exp);
        end
      end
      prev_hold = bus.out_valid && !bus.out_ready && !bus.flush && !rst;
      prev_out  = got;
    end
  end

  // ---------------- driver ----------------
  // Applies one cycle of stimulus just after a posedge, then updates the model
  // once the following posedge has taken effect.
  task automatic step(input logic iv, input logic ordy, input logic fl, input logic rs,
                      input logic [DATA_W-1:0] alu, input logic [DATA_W-1:0] wd,
                      input logic [REG_W-1:0] wr, input logic [3:0] ctl,
                      input logic br, input logic zr, input logic [DATA_W-1:0] tgt);
    logic acc;
    bus.in_valid      = iv;
    bus.out_ready     = ordy;
    bus.flush         = fl;
    rst               = rs;
    bus.alu_result    = alu;
    bus.write_data    = wd;
    bus.write_reg     = wr;
    bus.reg_write     = ctl[3];
    bus.mem_read      = ctl[2];
    bus.mem_write     = ctl[1];
    bus.mem_to_reg    = ctl[0];
    bus.branch        = br;
    bus.zero          = zr;
    bus.branch_target = tgt;
    acc = iv && (exp_q.size() < 2) && !fl && !rs;
    @(posedge clk);
    #1;
    if (rs || fl) exp_q.delete();
    else if (acc) exp_q.push_back({alu, wd, wr, ctl});
`ifdef EX_MEM_BRANCH_EN
    exp_pc_src = acc && br && zr;
`else
    exp_pc_src = 1'b0;
`endif
    exp_pc_branch = exp_pc_src ? tgt : '0;
  endtask

  task automatic idle(input logic ordy, input int n);
    for (int i = 0; i < n; i++) step(0, ordy, 0, 0, '0, '0, '0, '0, 0, 0, '0);
  endtask

  task automatic push(input logic ordy, input logic [DATA_W-1:0] alu, input logic [REG_W-1:0] wr);
    step(1, ordy, 0, 0, alu, alu ^ 32'h5555_0000, wr, 4'b1000, 0, 0, '0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    checks        = 0;
    failures      = 0;
    mon_en        = 1'b0;
    prev_hold     = 1'b0;
    prev_out      = '0;
    exp_pc_src    = 1'b0;
    exp_pc_branch = '0;
    rst           = 1'b1;

    // Reset, then the monitor checks the post-reset state.
    @(posedge clk);
    #1;
    step(0, 0, 0, 1, '0, '0, '0, '0, 0, 0, '0);
    mon_en = 1'b1;
    idle(0, 1);

    // Single pass: latency one, then empty again.
    step(1, 1, 0, 0, 32'h0000_0005, 32'h0, 5'd3, 4'b1000, 0, 0, '0);
    idle(1, 2);

    // Backpressure: two entries fill the buffer, then drain in order.
    push(0, 32'hA, 5'd1);
    push(0, 32'hB, 5'd2);
    idle(0, 2);
    idle(1, 3);

    // Flush while FULL with a new entry offered.
    push(0, 32'h11, 5'd4);
    push(0, 32'h22, 5'd5);
    step(1, 0, 1, 0, 32'h33, 32'h0, 5'd6, 4'b1111, 0, 0, '0);
    idle(1, 3);

    // Branch taken, then not taken.
    step(1, 1, 0, 0, 32'h44, 32'h0, 5'd7, 4'b0100, 1, 1, 32'h0040_0020);
    idle(1, 2);
    step(1, 1, 0, 0, 32'h55, 32'h0, 5'd8, 4'b0010, 1, 0, 32'h0040_0040);
    idle(1, 2);
    // Taken branch offered together with flush must not redirect.
    step(1, 1, 1, 0, 32'h66, 32'h0, 5'd9, 4'b0001, 1, 1, 32'h0040_0060);
    idle(1, 2);

    // Reset mid-stream while FULL.
    push(0, 32'h77, 5'd10);
    push(0, 32'h88, 5'd11);
    step(1, 1, 0, 1, 32'h99, 32'h0, 5'd12, 4'b1000, 1, 1, 32'h0040_0080);
    idle(1, 3);

    // Random traffic.
    for (int i = 0; i < 2000; i++) begin
      step($urandom_range(0, 99) < 60,
           $urandom_range(0, 99) < 65,
           $urandom_range(0, 99) < 3,
           $urandom_range(0, 199) == 0,
           $urandom, $urandom, 5'($urandom_range(0, 31)), 4'($urandom_range(0, 15)),
           $urandom_range(0, 1), $urandom_range(0, 1), $urandom);
    end

    idle(1, 4);
    check("drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
